// File: rtl/rf_debug_port_arbiter.sv
// Shares register-file read port 2 between the core and the debug probe.
// The core has priority; a starved debug read forces a one-cycle core stall.
module rf_debug_port_arbiter #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              core_rd_en,
  input  logic [ADDR_W-1:0] core_rd_addr,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_busy,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMaxC = CntW'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StPend, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] dbg_addr_q, dbg_addr_d;
  logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
  logic              dbg_ack_q;
  logic              starved;
  logic              grant;

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
      dbg_addr_q   <= '0;
      dbg_data_q   <= '0;
      dbg_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      dbg_addr_q   <= dbg_addr_d;
      dbg_data_q   <= dbg_data_d;
      dbg_ack_q    <= grant;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    dbg_addr_d   = dbg_addr_q;
    dbg_data_d   = dbg_data_q;
    unique case (state_q)
      StIdle: begin
        if (dbg_req) begin
          dbg_addr_d   = dbg_addr;
          starve_cnt_d = '0;
          state_d      = StPend;
        end
      end
      StPend: begin
        if (grant) begin
          // x0 reads as zero regardless of what the array returns
          dbg_data_d = (dbg_addr_q == '0) ? '0 : rf_rd_data;
          state_d    = StDone;
        end else if (!starved) begin
          starve_cnt_d = starve_cnt_q + CntW'(1);
        end
      end
      StDone: begin
        starve_cnt_d = '0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    starved    = (starve_cnt_q == StarveMaxC);
    grant      = (state_q == StPend) && (!core_rd_en || starved);
    core_stall = (state_q == StPend) && core_rd_en && starved;
    rf_rd_addr = grant ? dbg_addr_q : core_rd_addr;
    dbg_busy   = (state_q == StPend);
    dbg_ack    = dbg_ack_q;
    dbg_data   = dbg_data_q;
  end

endmodule

// File: tb/tb_rf_debug_port_arbiter.sv
// Randomised scoreboard bench for rf_debug_port_arbiter with a cycle-level
// reference model of the debug transaction and a decoupled ack monitor.
module tb_rf_debug_port_arbiter;

  localparam int unsigned STARVE_MAX = 8;

  logic        SYS_clk = 1'b0;
  logic        SYS_reset;
  logic        core_rd_en;
  logic [4:0]  core_rd_addr;
  logic        core_stall;
  logic        dbg_req;
  logic [4:0]  dbg_addr;
  logic        dbg_ack;
  logic [31:0] dbg_data;
  logic        dbg_busy;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;

  logic [31:0] rf_mem [32];
  assign rf_rd_data = rf_mem[rf_rd_addr];

  rf_debug_port_arbiter #(
    .ADDR_W    (5),
    .DATA_W    (32),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .SYS_clk     (SYS_clk),
    .SYS_reset   (SYS_reset),
    .core_rd_en  (core_rd_en),
    .core_rd_addr(core_rd_addr),
    .core_stall  (core_stall),
    .dbg_req     (dbg_req),
    .dbg_addr    (dbg_addr),
    .dbg_ack     (dbg_ack),
    .dbg_data    (dbg_data),
    .dbg_busy    (dbg_busy),
    .rf_rd_addr  (rf_rd_addr),
    .rf_rd_data  (rf_rd_data)
  );

  always #5 SYS_clk = ~SYS_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge SYS_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: cycle %0d got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  // Reference model: one outstanding read, counted losses to the core
  bit         m_pending = 0;
  bit         m_cooldown = 0;
  int         m_losses = 0;
  logic [4:0] m_addr = '0;

  always @(negedge SYS_clk) begin
    bit grant_now;
    exp_t e;
    if (SYS_reset) begin
      m_pending  = 0;
      m_cooldown = 0;
      m_losses   = 0;
      sb.delete();
    end else begin
      grant_now = m_pending && (!core_rd_en || m_losses >= STARVE_MAX);
      check("core_stall", 32'(core_stall),
            32'(m_pending && core_rd_en && m_losses >= STARVE_MAX));
      check("rf_rd_addr", 32'(rf_rd_addr), grant_now ? 32'(m_addr) : 32'(core_rd_addr));
      check("dbg_busy", 32'(dbg_busy), 32'(m_pending));
      if (grant_now) begin
        e.data = (m_addr == 5'd0) ? 32'd0 : rf_mem[m_addr];
        e.cyc  = cyc + 1;
        sb.push_back(e);
        m_pending  = 0;
        m_cooldown = 1;
      end else if (m_pending) begin
        if (m_losses < STARVE_MAX) m_losses++;
      end else if (m_cooldown) begin
        m_cooldown = 0;
      end else if (dbg_req) begin
        m_pending = 1;
        m_losses  = 0;
        m_addr    = dbg_addr;
      end
    end
  end

  logic [31:0] last_data = '0;

  always @(negedge SYS_clk) begin
    exp_t e;
    if (SYS_reset) begin
      last_data = '0;
    end else if (dbg_ack) begin
      if (sb.size() == 0) begin
        check("ack_unexpected", 32'(dbg_ack), 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_cycle", 32'(cyc), 32'(e.cyc));
        check("ack_data", dbg_data, e.data);
        last_data = e.data;
      end
    end else begin
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        check("ack_missing", 32'(dbg_ack), 32'd1);
      end
      check("dbg_data_hold", dbg_data, last_data);
    end
  end

  // Called just after a rising edge; returns just after the next one
  task automatic step(input logic en, input logic [4:0] ca, input logic rq,
                      input logic [4:0] da);
    core_rd_en   = en;
    core_rd_addr = ca;
    dbg_req      = rq;
    dbg_addr     = da;
    @(posedge SYS_clk);
    #1;
  endtask

  initial begin
    int density;
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    rf_mem[0] = 32'hFFFF_FFFF;
    rf_mem[5] = 32'hDEAD_BEEF;
    rf_mem[8] = 32'h0000_0064;
    SYS_reset    = 1'b1;
    core_rd_en   = 1'b1;
    core_rd_addr = 5'd7;
    dbg_req      = 1'b1;
    dbg_addr     = 5'd3;
    repeat (2) @(posedge SYS_clk);
    #1;
    check("reset_ack", 32'(dbg_ack), 32'd0);
    check("reset_busy", 32'(dbg_busy), 32'd0);
    check("reset_data", dbg_data, 32'd0);
    check("reset_stall", 32'(core_stall), 32'd0);
    check("reset_rf_addr", 32'(rf_rd_addr), 32'd7);
    SYS_reset = 1'b0;

    // Idle core, read of x8
    step(1'b0, 5'd0, 1'b1, 5'd8);
    repeat (4) step(1'b0, 5'd0, 1'b0, 5'd0);
    // Core always busy, forced grant on x5
    step(1'b1, 5'd3, 1'b1, 5'd5);
    repeat (12) step(1'b1, 5'd3, 1'b0, 5'd5);
    // Intermittent core
    step(1'b1, 5'd3, 1'b1, 5'd7);
    repeat (3) step(1'b1, 5'd3, 1'b0, 5'd7);
    repeat (4) step(1'b0, 5'd3, 1'b0, 5'd7);
    // x0 reads as zero
    step(1'b0, 5'd0, 1'b1, 5'd0);
    repeat (3) step(1'b0, 5'd0, 1'b0, 5'd0);
    // Held request: acks every third cycle
    repeat (12) step(1'b0, 5'd1, 1'b1, 5'd8);
    repeat (2) step(1'b0, 5'd1, 1'b0, 5'd8);
    // Address changes after acceptance
    step(1'b1, 5'd2, 1'b1, 5'd8);
    step(1'b1, 5'd2, 1'b1, 5'd9);
    repeat (2) step(1'b1, 5'd2, 1'b0, 5'd9);
    repeat (3) step(1'b0, 5'd2, 1'b0, 5'd9);

    // Reset while pending
    step(1'b1, 5'd4, 1'b1, 5'd6);
    repeat (3) step(1'b1, 5'd4, 1'b0, 5'd6);
    @(negedge SYS_clk);
    #2;
    SYS_reset = 1'b1;
    #1;
    check("midreset_busy", 32'(dbg_busy), 32'd0);
    check("midreset_data", dbg_data, 32'd0);
    check("midreset_stall", 32'(core_stall), 32'd0);
    check("midreset_ack", 32'(dbg_ack), 32'd0);
    @(negedge SYS_clk);
    @(posedge SYS_clk);
    #1;
    SYS_reset = 1'b0;
    repeat (6) step(1'b1, 5'd4, 1'b0, 5'd6);
    repeat (3) step(1'b0, 5'd4, 1'b0, 5'd6);

    // Randomised traffic with varying core load
    for (int b = 0; b < 30; b++) begin
      density = $urandom_range(0, 100);
      for (int i = 0; i < 100; i++) begin
        step(32'($urandom_range(0, 99)) < 32'(density), 5'($urandom),
             1'($urandom), 5'($urandom));
      end
    end
    repeat (6) step(1'b0, 5'd0, 1'b0, 5'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
